// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the hazard sequencer
//
// Purpose: state encoding and register-file constants used by hazard_ctrl.
// Ports:   none (package).
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard inputs and stall/flush controls
//
// Purpose: bundles the per-stage hazard inputs and the register hold/bubble
//          controls shared between the pipeline and hazard_ctrl.
// Ports:   master - pipeline side (drives hazard inputs, receives controls).
//          slave  - hazard_ctrl side (reads hazard inputs, drives controls).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_uses_rs;
  logic             ID_uses_rt;
  logic             ID_effective;
  logic             EX_MemRead;
  logic [4:0]       EX_rd;
  logic             EX_effective;
  logic             EX_redirect;
  logic             EX_mdu_start;
  logic             MEM_halt;

  logic             PC_Enable;
  logic             IF_ID_Enable;
  logic             IF_ID_rst;
  logic             ID_EX_Enable;
  logic             ID_EX_rst;
  logic             EX_MEM_rst;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_effective,
           EX_MemRead, EX_rd, EX_effective, EX_redirect, EX_mdu_start, MEM_halt,
    input  PC_Enable, IF_ID_Enable, IF_ID_rst, ID_EX_Enable, ID_EX_rst,
           EX_MEM_rst, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_effective,
           EX_MemRead, EX_rd, EX_effective, EX_redirect, EX_mdu_start, MEM_halt,
    output PC_Enable, IF_ID_Enable, IF_ID_rst, ID_EX_Enable, ID_EX_rst,
           EX_MEM_rst, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter
//
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:   clk   - clock
//          clear - synchronous clear to zero (wins over inc)
//          inc   - count one event this cycle
//          cnt   - current count
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: resolves load-use, branch redirect, MDU occupancy and halt into
//          hold/bubble controls for PC, IF_ID, ID_EX and EX_MEM, and counts
//          stall cycles and accepted flushes.
// Ports:   clk - pipeline clock
//          rst - synchronous active-high reset
//          hz  - hazard inputs and control outputs (slave modport)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  // Start cycle itself is not a hold, so the wait counts MDU_LAT-1 cycles.
  localparam logic [3:0] MDU_INIT = 4'(MDU_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;

  logic load_use;
  logic pc_hold, ifid_hold, ifid_bub, idex_hold, idex_bub, exmem_bub, halted;
  logic stall_inc, flush_inc;

  assign load_use = hz.EX_effective && hz.EX_MemRead && (hz.EX_rd != REG_ZERO) &&
                    hz.ID_effective &&
                    ((hz.ID_uses_rs && (hz.ID_rs == hz.EX_rd)) ||
                     (hz.ID_uses_rt && (hz.ID_rt == hz.EX_rd)));

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    pc_hold   = 1'b0;
    ifid_hold = 1'b0;
    ifid_bub  = 1'b0;
    idex_hold = 1'b0;
    idex_bub  = 1'b0;
    exmem_bub = 1'b0;
    halted    = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.MEM_halt) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_hold = 1'b1;
          exmem_bub = 1'b1;
          state_d   = HALT;
        end else if (hz.EX_redirect) begin
          // ID holds a wrong-path instruction, so a load-use match is moot.
          ifid_bub  = 1'b1;
          idex_bub  = 1'b1;
          flush_inc = 1'b1;
          if (hz.EX_mdu_start) begin
            state_d   = MDU_WAIT;
            mdu_cnt_d = MDU_INIT;
          end
        end else if (hz.EX_mdu_start) begin
          state_d   = MDU_WAIT;
          mdu_cnt_d = MDU_INIT;
        end else if (load_use) begin
          // Single bubble: the load moves on next cycle, clearing the match.
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_bub  = 1'b1;
        end
      end

      MDU_WAIT: begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
        exmem_bub = 1'b1;
        if (hz.MEM_halt) begin
          state_d = HALT;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 4'd1;
          if (mdu_cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
      end

      HALT: begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
        exmem_bub = 1'b1;
        halted    = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // The cycle that enters HALT still counts; frozen HALT cycles do not.
  assign stall_inc = pc_hold && (state_q != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mdu_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .cnt   (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_inc),
    .cnt   (hz.flush_cnt)
  );

  assign hz.PC_Enable    = pc_hold;
  assign hz.IF_ID_Enable = ifid_hold;
  assign hz.IF_ID_rst    = ifid_bub;
  assign hz.ID_EX_Enable = idex_hold;
  assign hz.ID_EX_rst    = idex_bub;
  assign hz.EX_MEM_rst   = exmem_bub;
  assign hz.halted       = halted;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CW = 4;

  // Control vector order: PC_En, IF_ID_En, IF_ID_rst, ID_EX_En, ID_EX_rst, EX_MEM_rst, halted
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_FL   = 7'b0010100;
  localparam logic [6:0] C_HOLD = 7'b1101010;
  localparam logic [6:0] C_HALT = 7'b1101011;

  typedef struct {
    string         tag;
    logic [6:0]    ctl;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  logic clk;
  logic rst;

  exp_t          sb[$];
  exp_t          mon_e;
  int            total;
  int            bad;
  logic [CW-1:0] exp_st;
  logic [CW-1:0] exp_fl;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".ctl"},
            {25'd0, hz.PC_Enable, hz.IF_ID_Enable, hz.IF_ID_rst, hz.ID_EX_Enable,
             hz.ID_EX_rst, hz.EX_MEM_rst, hz.halted},
            {25'd0, mon_e.ctl});
      check({mon_e.tag, ".stall"}, 32'(hz.stall_cnt), 32'(mon_e.st));
      check({mon_e.tag, ".flush"}, 32'(hz.flush_cnt), 32'(mon_e.fl));
    end
  end

  task automatic clear_in();
    hz.ID_rs        = 5'd0;
    hz.ID_rt        = 5'd0;
    hz.ID_uses_rs   = 1'b0;
    hz.ID_uses_rt   = 1'b0;
    hz.ID_effective = 1'b0;
    hz.EX_MemRead   = 1'b0;
    hz.EX_rd        = 5'd0;
    hz.EX_effective = 1'b0;
    hz.EX_redirect  = 1'b0;
    hz.EX_mdu_start = 1'b0;
    hz.MEM_halt     = 1'b0;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [6:0] ctl, input bit si, input bit fi);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.st  = exp_st;
    e.fl  = exp_fl;
    sb.push_back(e);
    if (si && exp_st != {CW{1'b1}}) exp_st = exp_st + 1'b1;
    if (fi && exp_fl != {CW{1'b1}}) exp_fl = exp_fl + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_st = '0;
    exp_fl = '0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    hz.EX_effective = 1'b1;
    hz.EX_MemRead   = 1'b1;
    hz.EX_rd        = rd;
    hz.ID_effective = 1'b1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    exp_st = '0;
    exp_fl = '0;
    rst    = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("reset", C_IDLE, 0, 0);

    // Load-use on rs, then release.
    set_load(5'd5); hz.ID_rs = 5'd5; hz.ID_uses_rs = 1'b1;
    cyc("lu_rs", C_LU, 1, 0);
    clear_in();
    cyc("lu_after", C_IDLE, 0, 0);

    // r0 never creates a dependency.
    set_load(5'd0); hz.ID_rs = 5'd0; hz.ID_uses_rs = 1'b1;
    cyc("lu_r0", C_IDLE, 0, 0);
    // Bubble in ID never stalls.
    set_load(5'd5); hz.ID_rs = 5'd5; hz.ID_uses_rs = 1'b1; hz.ID_effective = 1'b0;
    cyc("lu_noeff", C_IDLE, 0, 0);
    // Match on a field the instruction does not read.
    clear_in(); set_load(5'd9); hz.ID_rs = 5'd9;
    cyc("lu_unused", C_IDLE, 0, 0);
    // Load-use on rt.
    clear_in(); set_load(5'd7); hz.ID_rt = 5'd7; hz.ID_uses_rt = 1'b1; hz.ID_rs = 5'd3;
    cyc("lu_rt", C_LU, 1, 0);
    clear_in();
    cyc("lu_rt_after", C_IDLE, 0, 0);

    // Redirect beats load-use.
    do_reset();
    set_load(5'd5); hz.ID_rs = 5'd5; hz.ID_uses_rs = 1'b1; hz.EX_redirect = 1'b1;
    cyc("redir_lu", C_FL, 0, 1);
    clear_in();
    cyc("redir_after", C_IDLE, 0, 0);

    // MDU start: no hold on start, then three hold cycles; hazards ignored meanwhile.
    hz.EX_mdu_start = 1'b1;
    cyc("mdu_start", C_IDLE, 0, 0);
    clear_in();
    cyc("mdu_w1", C_HOLD, 1, 0);
    set_load(5'd5); hz.ID_rs = 5'd5; hz.ID_uses_rs = 1'b1; hz.EX_redirect = 1'b1;
    cyc("mdu_w2_ign", C_HOLD, 1, 0);
    clear_in();
    cyc("mdu_w3", C_HOLD, 1, 0);
    cyc("mdu_done", C_IDLE, 0, 0);

    // Redirect together with MDU start: flush, then the MDU wait.
    hz.EX_redirect = 1'b1; hz.EX_mdu_start = 1'b1;
    cyc("redir_mdu", C_FL, 0, 1);
    clear_in();
    for (int i = 0; i < 3; i++) cyc("redir_mdu_w", C_HOLD, 1, 0);
    cyc("redir_mdu_done", C_IDLE, 0, 0);

    // Halt from RUN: entry cycle counts a stall, frozen cycles do not.
    hz.MEM_halt = 1'b1;
    cyc("halt_enter", C_HOLD, 1, 0);
    clear_in();
    for (int i = 0; i < 100; i++) begin
      hz.EX_redirect  = 1'($urandom_range(0, 1));
      hz.EX_mdu_start = 1'($urandom_range(0, 1));
      hz.MEM_halt     = 1'($urandom_range(0, 1));
      cyc("halt_hold", C_HALT, 0, 0);
    end
    do_reset();
    cyc("halt_rst", C_IDLE, 0, 0);

    // Halt wins over an MDU wait.
    hz.EX_mdu_start = 1'b1;
    cyc("mh_start", C_IDLE, 0, 0);
    clear_in(); hz.MEM_halt = 1'b1;
    cyc("mh_enter", C_HOLD, 1, 0);
    clear_in();
    cyc("mh_halted", C_HALT, 0, 0);
    do_reset();

    // Reset on the second MDU wait cycle.
    hz.EX_mdu_start = 1'b1;
    cyc("mr_start", C_IDLE, 0, 0);
    clear_in();
    cyc("mr_w1", C_HOLD, 1, 0);
    do_reset();
    cyc("mr_after", C_IDLE, 0, 0);

    // Counter saturation at all-ones.
    set_load(5'd4); hz.ID_rt = 5'd4; hz.ID_uses_rt = 1'b1;
    for (int i = 0; i < 18; i++) cyc("sat_stall", C_LU, 1, 0);
    clear_in();
    hz.EX_redirect = 1'b1;
    for (int i = 0; i < 18; i++) cyc("sat_flush", C_FL, 0, 1);
    clear_in();
    cyc("sat_end", C_IDLE, 0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the hold (Enable, 1 = hold) and bubble (rst, 1 = clear) inputs of the IF_ID, ID_EX and EX_MEM registers, plus the PC hold.
- Resolves four hazard sources with fixed priority: load-use, taken branch/jump redirect, multi-cycle MDU occupancy and program halt.
- Keeps performance counters for stall cycles and flushes.

Parameters:
- MDU_LAT, 4, cycles the multiply/divide unit stays busy after a start pulse (legal range 2..15).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_uses_rs  input  1  ID instruction reads rs.
- ID_uses_rt  input  1  ID instruction reads rt.
- ID_effective  input  1  Effective bit of IF_ID output.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_rd  input  5  destination register of the EX instruction.
- EX_effective  input  1  Effective bit of ID_EX output.
- EX_redirect  input  1  EX resolved a taken branch/jump (PC redirect this cycle).
- EX_mdu_start  input  1  EX holds a mult/div; one-cycle start pulse.
- MEM_halt  input  1  effective halt syscall in MEM.
- PC_Enable  output  1  1 = hold PC.
- IF_ID_Enable  output  1  1 = hold IF_ID.
- IF_ID_rst  output  1  1 = bubble into IF_ID.
- ID_EX_Enable  output  1  1 = hold ID_EX.
- ID_EX_rst  output  1  1 = bubble into ID_EX.
- EX_MEM_rst  output  1  1 = bubble into EX_MEM.
- halted  output  1  pipeline frozen by halt.
- stall_cnt  output  CNT_W  cycles with PC held, excluding HALT.
- flush_cnt  output  CNT_W  redirect events accepted.

Behaviour:
- States: RUN, MDU_WAIT, HALT. State, the MDU counter (4 bits) and the perf counters are registered. Control outputs are combinational from state and inputs, valid in the same cycle.
- Reset: state = RUN, mdu_cnt = 0, stall_cnt = 0, flush_cnt = 0, halted = 0. With state RUN and all inputs 0, every control output is 0.
- load_use = EX_effective & EX_MemRead & EX_rd != 0 & ID_effective & ((ID_uses_rs & ID_rs == EX_rd) | (ID_uses_rt & ID_rt == EX_rd)).
- RUN, priority from highest:
  1. MEM_halt: all Enables = 1, EX_MEM_rst = 1, next state HALT.
  2. EX_redirect: IF_ID_rst = 1, ID_EX_rst = 1, all Enables = 0; flush_cnt += 1. load_use is ignored because the ID instruction is wrong-path. If EX_mdu_start is also 1, next state MDU_WAIT, since the redirecting instruction is not the MDU op.
  3. EX_mdu_start without redirect: next state MDU_WAIT, mdu_cnt = MDU_LAT - 1. No hold in this cycle; the MDU op advances to MEM.
  4. load_use: PC_Enable = 1, IF_ID_Enable = 1, ID_EX_rst = 1. Exactly one bubble; not self-repeating, because the load leaves EX.
- MDU_WAIT:
  - PC_Enable, IF_ID_Enable and ID_EX_Enable = 1; EX_MEM_rst = 1 (bubbles into MEM).
  - mdu_cnt decrements each cycle. At mdu_cnt == 1 the next state is RUN, so exactly MDU_LAT-1 hold cycles follow the start cycle.
  - EX_redirect and load_use are ignored here because EX is frozen.
  - MEM_halt takes priority: next state HALT, same outputs as in RUN priority 1.
- HALT: all Enables = 1, EX_MEM_rst = 1, halted = 1. Exit only via rst.
- stall_cnt increments every cycle with PC_Enable = 1 and state != HALT, including the cycle that enters HALT. Both counters saturate at all-ones, no wrap.
- rst mid-MDU_WAIT or in HALT: next cycle state = RUN and all counters = 0. rst overrides every input.

Decomposition:
- Shared package: state encoding constants (RUN = 2'd0, MDU_WAIT = 2'd1, HALT = 2'd2), REG_ZERO = 5'd0.
- One sub-module: sat_counter (CNT_W, inc, clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: EX load with EX_rd = 5, ID_rs = 5, ID_uses_rs = 1 -> one cycle of PC_Enable = 1, IF_ID_Enable = 1, ID_EX_rst = 1; next cycle all 0; stall_cnt = 1.
- EX_rd = 0 with ID_rs = 0, or ID_effective = 0 -> no stall, all outputs 0.
- load_use and EX_redirect in the same cycle -> IF_ID_rst = 1, ID_EX_rst = 1, PC_Enable = 0; flush_cnt = 1, stall_cnt = 0.
- EX_mdu_start with MDU_LAT = 4 -> start cycle has no hold, then 3 cycles of PC/IF_ID/ID_EX hold with EX_MEM_rst = 1, then RUN; stall_cnt = 3.
- MEM_halt -> halted = 1 and all holds stay asserted for 100 cycles, stall_cnt stops; rst -> halted = 0, counters 0.
- rst asserted on the 2nd MDU_WAIT cycle -> next cycle state RUN and all control outputs 0.
